jtopl_cendiv: RTL and testbench

JTOPL_CENDIV -- requirements
Module: jtopl_cendiv

---
 rtl/jtopl_pkg.sv | 17 +
 rtl/jtopl_modcnt.sv | 34 +++
 rtl/jtopl_cendiv.sv | 108 ++++++++++
 tb/tb_jtopl_cendiv.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// jtopl_pkg -- shared OPL timing constants.
//   OPL_SLOTS    : operator slots per sample frame
//   OPL_SLOT_W   : width of the slot counter
//   OPL_OP_DIV   : operator clock-enable divide ratio after reset
//   OPL_DIV_W    : width of the operator divide counter
//   OPL_TMR_PRE  : sample frames per timer tick
//   OPL_TMR_W    : width of the timer prescaler
package jtopl_pkg;

   localparam int unsigned OPL_SLOTS   = 18;
   localparam int unsigned OPL_SLOT_W  = 5;
   localparam int unsigned OPL_OP_DIV  = 4;
   localparam int unsigned OPL_DIV_W   = 4;
   localparam int unsigned OPL_TMR_PRE = 4;
   localparam int unsigned OPL_TMR_W   = 3;

endpackage

// File: rtl/jtopl_modcnt.sv
// jtopl_modcnt -- generic modulo-MOD counter with a registered wrap pulse.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : advance the count by one on this clk
//   cnt   : current count, 0..MOD-1
//   pulse : high for one clk after the edge that moved cnt from MOD-1 to 0
module jtopl_modcnt #(
   parameter int unsigned W   = 5,
   parameter int unsigned MOD = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         pulse
);

   logic at_top;

   assign at_top = (cnt == W'(MOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else begin
         pulse <= en && at_top;
         if (en) begin
            cnt <= at_top ? '0 : cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/jtopl_cendiv.sv
// jtopl_cendiv -- OPL operator clock-enable divider with slot and timer
// prescaler counters.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   cen     : master clock enable
//   div_ld  : one-cycle request to load a new divide ratio
//   div_val : new divide ratio N (0 and 1 both mean N=1)
//   cenop   : one-clk pulse at operator rate
//   phase   : current divide counter value, 0..N-1
//   slot    : current operator slot, 0..SLOTS-1
//   zero    : one-clk pulse when slot wraps to 0 (sample boundary)
//   cen_tmr : one-clk pulse every TPRE sample frames
module jtopl_cendiv
   import jtopl_pkg::*;
#(
   parameter int unsigned DW      = OPL_DIV_W,
   parameter int unsigned DIV_DEF = OPL_OP_DIV,
   parameter int unsigned SLOTS   = OPL_SLOTS,
   parameter int unsigned SW      = OPL_SLOT_W,
   parameter int unsigned TPRE    = OPL_TMR_PRE,
   parameter int unsigned TW      = OPL_TMR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          div_ld,
   input  logic [DW-1:0] div_val,
   output logic          cenop,
   output logic [DW-1:0] phase,
   output logic [SW-1:0] slot,
   output logic          zero,
   output logic          cen_tmr
);

   // The active ratio is held as its last phase value (N-1) so the wrap
   // test is a plain equality; ratios 0 and 1 both collapse to 0.
   function automatic logic [DW-1:0] last_phase(input logic [DW-1:0] v);
      return (v == '0) ? '0 : v - DW'(1);
   endfunction

   localparam logic [DW-1:0] DEF_LAST = last_phase(DW'(DIV_DEF));

   logic [DW-1:0] act_last;
   logic [DW-1:0] pend_val;
   logic          pend;
   logic          wrap;
   logic          slot_tick;
   logic [TW-1:0] tmr_pre_unused;

   assign wrap      = cen && (phase == act_last);
   assign slot_tick = wrap && (slot == SW'(SLOTS - 1));

   // A load that coincides with a wrap goes straight to the active ratio,
   // bypassing the pending register, so it governs the very next period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= '0;
         act_last <= DEF_LAST;
         pend_val <= '0;
         pend     <= 1'b0;
         cenop    <= 1'b0;
      end else begin
         cenop <= wrap;
         if (wrap) begin
            phase <= '0;
            pend  <= 1'b0;
            if (div_ld) begin
               act_last <= last_phase(div_val);
            end else if (pend) begin
               act_last <= last_phase(pend_val);
            end
         end else begin
            if (cen) begin
               phase <= phase + DW'(1);
            end
            if (div_ld) begin
               pend     <= 1'b1;
               pend_val <= div_val;
            end
         end
      end
   end

   // Both counters advance on the same edge that raises cenop, so slot
   // already shows its new value while cenop/zero/cen_tmr are high.
   jtopl_modcnt #(
      .W   (SW),
      .MOD (SLOTS)
   ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wrap),
      .cnt   (slot),
      .pulse (zero)
   );

   jtopl_modcnt #(
      .W   (TW),
      .MOD (TPRE)
   ) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (slot_tick),
      .cnt   (tmr_pre_unused),
      .pulse (cen_tmr)
   );

endmodule

// File: tb/tb_jtopl_cendiv.sv
// tb_jtopl_cendiv -- self-checking bench for jtopl_cendiv.
// A behavioural model tracks the operator period in cen counts and the total
// number of operator ticks since reset; slot, zero and cen_tmr follow from
// that total by modular arithmetic.
module tb_jtopl_cendiv;

   localparam int unsigned DW      = 4;
   localparam int unsigned DIV_DEF = 4;
   localparam int unsigned SLOTS   = 18;
   localparam int unsigned SW      = 5;
   localparam int unsigned TPRE    = 4;
   localparam int unsigned TW      = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cen;
   logic          div_ld;
   logic [DW-1:0] div_val;
   logic          cenop;
   logic [DW-1:0] phase;
   logic [SW-1:0] slot;
   logic          zero;
   logic          cen_tmr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jtopl_cendiv #(
      .DW      (DW),
      .DIV_DEF (DIV_DEF),
      .SLOTS   (SLOTS),
      .SW      (SW),
      .TPRE    (TPRE),
      .TW      (TW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen     (cen),
      .div_ld  (div_ld),
      .div_val (div_val),
      .cenop   (cenop),
      .phase   (phase),
      .slot    (slot),
      .zero    (zero),
      .cen_tmr (cen_tmr)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_n;       // active ratio N
   int m_pos;     // cen cycles elapsed in the current period
   int m_ops;     // operator ticks since reset
   bit m_pend;
   int m_pval;
   bit e_cenop, e_zero, e_tmr;

   function automatic int eff(input int v);
      return (v < 2) ? 1 : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = DIV_DEF; m_pos = 0; m_ops = 0; m_pend = 0; m_pval = 0;
         e_cenop = 0; e_zero = 0; e_tmr = 0;
      end else begin
         e_cenop = 0; e_zero = 0; e_tmr = 0;
         if (cen && (m_pos == m_n - 1)) begin
            m_pos   = 0;
            m_ops   = m_ops + 1;
            e_cenop = 1;
            e_zero  = (m_ops % SLOTS) == 0;
            e_tmr   = (m_ops % (SLOTS * TPRE)) == 0;
            if (div_ld)      m_n = eff(int'(div_val));
            else if (m_pend) m_n = eff(m_pval);
            m_pend = 0;
         end else begin
            if (cen) m_pos = m_pos + 1;
            if (div_ld) begin
               m_pend = 1;
               m_pval = int'(div_val);
            end
         end
      end
   end

   always @(negedge clk) begin
      check("phase",   int'(phase),   m_pos);
      check("slot",    int'(slot),    m_ops % SLOTS);
      check("cenop",   int'(cenop),   int'(e_cenop));
      check("zero",    int'(zero),    int'(e_zero));
      check("cen_tmr", int'(cen_tmr), int'(e_tmr));
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      int first_zero;
      int first_tmr;
      bit exp_b;

      rst_n = 1'b1; cen = 1'b0; div_ld = 1'b0; div_val = '0;
      #1 rst_n = 1'b0;
      repeat (3) edge1();
      check("rst_phase", int'(phase), 0);
      check("rst_slot",  int'(slot),  0);
      check("rst_cenop", int'(cenop), 0);
      check("rst_tmr",   int'(cen_tmr), 0);

      // N=4, cen always high: cenop on edges 4, 8, 12
      cen = 1'b1; rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         edge1();
         check("n4_cenop", int'(cenop), (k % 4 == 0) ? 1 : 0);
         check("n4_phase", int'(phase), k % 4);
      end

      // cen every second clk: one cenop per 8 clks
      cnt = 0;
      for (int k = 0; k < 32; k++) begin
         cen = (k % 2 == 0);
         edge1();
         cnt += int'(cenop);
      end
      check("half_cen_cenops", cnt, 4);

      // ratio 2 loaded at phase 1, then ratio 0 (acts as 1)
      cen = 1'b1;
      edge1();
      check("pre_ld_phase", int'(phase), 1);
      for (int k = 1; k <= 16; k++) begin
         div_ld  = (k == 1) || (k == 10);
         div_val = (k == 1) ? 4'd2 : 4'd0;
         edge1();
         exp_b = (k == 3) || (k == 5) || (k == 7) || (k == 9) || (k >= 11);
         check("ld_cenop", int'(cenop), int'(exp_b));
      end
      check("n1_phase", int'(phase), 0);

      // loads on wrap cycles take effect for the immediately following period
      for (int k = 0; k <= 10; k++) begin
         div_ld  = (k == 0) || (k == 4);
         div_val = (k == 0) ? 4'd4 : 4'd3;
         edge1();
         exp_b = (k == 0) || (k == 4) || (k == 7) || (k == 10);
         check("wrapld_cenop", int'(cenop), int'(exp_b));
      end

      // reset at phase 2 with a pending ratio 7: it must be discarded
      div_ld = 1'b1; div_val = 4'd7;
      edge1();
      div_ld = 1'b0;
      edge1();
      check("prerst_phase", int'(phase), 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_phase", int'(phase), 0);
      check("arst_slot",  int'(slot),  0);
      check("arst_cenop", int'(cenop), 0);
      edge1();
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         edge1();
         check("postrst_cenop", int'(cenop), (k % 4 == 0) ? 1 : 0);
      end

      // N=1 long run: zero every 18 ticks, cen_tmr every 72
      rst_n = 1'b0;
      edge1();
      rst_n = 1'b1; div_ld = 1'b1; div_val = 4'd1;
      first_zero = -1; first_tmr = -1; cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         edge1();
         div_ld = 1'b0;
         if (zero) begin
            cnt++;
            if (first_zero < 0) first_zero = k;
         end
         if (cen_tmr && first_tmr < 0) first_tmr = k;
      end
      check("first_zero_edge", first_zero, 21);
      check("first_tmr_edge",  first_tmr,  75);
      check("zero_count",      cnt,        5);

      // randomized traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         cen     = ($urandom % 4) != 0;
         div_ld  = ($urandom % 12) == 0;
         div_val = DW'($urandom);
         if (($urandom % 700) == 0) begin
            rst_n = 1'b0;
            #3 rst_n = 1'b1;
         end
         if ((k / 300) % 3 == 2) cen = 1'b0;
         edge1();
      end

      cen = 1'b0; div_ld = 1'b0;
      repeat (3) edge1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
